// File: rtl/rate_scheduler_pkg.sv
// Shared constants for the two-channel rate scheduler.
// FSM encodings, channel count and default register width.
package rate_scheduler_pkg;

  localparam int NUM_CH    = 2;
  localparam int DEF_WIDTH = 32;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/rate_scheduler_if.sv
// Divisor update handshake between a configuring master and the scheduler.
// A transfer happens on an edge with cfg_valid && cfg_ready.
interface rate_scheduler_if
  import rate_scheduler_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_sel;
  logic [WIDTH-1:0] cfg_div;

  modport master (
    output cfg_valid,
    output cfg_sel,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_sel,
    input  cfg_div,
    output cfg_ready
  );

endinterface

// File: rtl/rate_channel.sv
// One divider channel: counter, divisor, pending update, tick and clk_out.
// Divisor changes only at a wrap or while stopped, so cnt never exceeds div-1.
module rate_channel #(
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             active,
  input  logic             stop,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_div,
  output logic             tick,
  output logic             clk_out,
  output logic             pend
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] pval;
  logic [WIDTH-1:0] fixed;
  logic             wrap;

  assign fixed = (wr_div == '0) ? ONE : wr_div;
  assign wrap  = (cnt == div - ONE);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt     <= '0;
      div     <= DEF_DIV;
      pval    <= '0;
      pend    <= 1'b0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else if (!active) begin
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
      if (wr) div <= fixed;
    end else if (stop) begin
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
      pend    <= 1'b0;
      if (wr) div <= fixed;
      else if (pend) div <= pval;
    end else begin
      if (wrap) begin
        cnt     <= '0;
        tick    <= 1'b1;
        clk_out <= ~clk_out;
        if (pend) begin
          div  <= pval;
          pend <= 1'b0;
        end
      end else begin
        cnt  <= cnt + ONE;
        tick <= 1'b0;
      end
      // accept only happens with nothing pending, so this never drops a value
      if (wr) begin
        pend <= 1'b1;
        pval <= fixed;
      end
    end
  end

endmodule

// File: rtl/rate_scheduler.sv
// Two-channel rate scheduler: IDLE/RUN FSM plus update handshake arbitration.
// cfg_ready is a pure decode of the channels' pending registers.
module rate_scheduler
  import rate_scheduler_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEFAULT_DIV0 = 1000,
  parameter int DEFAULT_DIV1 = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              enable,
  rate_scheduler_if.slave   cfg,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] clk_out,
  output logic              running
);

  logic [0:0]        state;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] wr;
  logic              active;
  logic              stop;
  logic              accept;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: if (enable)  state <= RUN;
        RUN:  if (!enable) state <= IDLE;
      endcase
    end
  end

  assign active        = (state == RUN);
  assign stop          = active & ~enable;
  assign running       = active;
  assign cfg.cfg_ready = ~|pend;
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;
  assign wr            = {accept & cfg.cfg_sel, accept & ~cfg.cfg_sel};

  rate_channel #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV0)
  ) u_ch0 (
    .clk_in  (clk_in),
    .rst     (rst),
    .active  (active),
    .stop    (stop),
    .wr      (wr[0]),
    .wr_div  (cfg.cfg_div),
    .tick    (tick_out[0]),
    .clk_out (clk_out[0]),
    .pend    (pend[0])
  );

  rate_channel #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV1)
  ) u_ch1 (
    .clk_in  (clk_in),
    .rst     (rst),
    .active  (active),
    .stop    (stop),
    .wr      (wr[1]),
    .wr_div  (cfg.cfg_div),
    .tick    (tick_out[1]),
    .clk_out (clk_out[1]),
    .pend    (pend[1])
  );

endmodule

// File: tb/tb_rate_scheduler.sv
// Scoreboard bench for rate_scheduler: expected tick cycles are queued
// by the stimulus and popped by a negedge monitor on every tick_out pulse.
module tb_rate_scheduler;

  typedef struct {
    int at;
    bit lvl;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] tick_out;
  logic [1:0] clk_out;
  logic       running;

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   e0;
  bit   nxt_lvl[2];
  exp_t q0[$];
  exp_t q1[$];
  exp_t e;

  rate_scheduler_if #(.WIDTH(32)) cfg_if ();

  rate_scheduler #(
    .WIDTH        (32),
    .DEFAULT_DIV0 (1000),
    .DEFAULT_DIV1 (8)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .enable   (enable),
    .cfg      (cfg_if),
    .tick_out (tick_out),
    .clk_out  (clk_out),
    .running  (running)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d",
               nm, cyc, act, exp);
    end
  endtask

  // Monitor: every tick must match the head of that channel's queue.
  always @(negedge clk_in) begin
    for (int i = 0; i < 2; i++) begin
      if (tick_out[i] === 1'b1) begin
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tick ch%0d at cycle %0d", i, cyc);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("tick_cycle_ch%0d", i), 64'(cyc), 64'(e.at));
          chk($sformatf("tick_level_ch%0d", i), 64'(clk_out[i]), 64'(e.lvl));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic push(input int ch, input int at);
    exp_t x;
    x.at = at;
    x.lvl = nxt_lvl[ch];
    nxt_lvl[ch] = ~nxt_lvl[ch];
    if (ch == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask

  task automatic start_run();
    enable = 1'b1;
    step();
    e0 = cyc;
    nxt_lvl[0] = 1'b1;
    nxt_lvl[1] = 1'b1;
  endtask

  task automatic drop();
    enable = 1'b0;
    step();
    step();
    chk("drain_ch0", 64'(q0.size()), 64'd0);
    chk("drain_ch1", 64'(q1.size()), 64'd0);
    q0.delete();
    q1.delete();
  endtask

  task automatic do_reset();
    enable = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input bit sel, input int div);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_sel = sel;
    cfg_if.cfg_div = div;
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_sel = 1'b0;
    cfg_if.cfg_div = '0;

    // reset state
    do_reset();
    chk("rst_tick", 64'(tick_out), 64'd0);
    chk("rst_clk", 64'(clk_out), 64'd0);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_ready", 64'(cfg_if.cfg_ready), 64'd1);

    // default divisors 1000 / 8
    start_run();
    chk("run_running", 64'(running), 64'd1);
    for (int k = 1; k <= 125; k++) push(1, e0 + 8 * k);
    push(0, e0 + 1000);
    run_to(e0 + 1002);
    drop();
    chk("idle_running", 64'(running), 64'd0);

    // divisor written in IDLE takes effect immediately
    do_reset();
    cfg_write(1'b1, 3);
    start_run();
    for (int k = 1; k <= 6; k++) push(1, e0 + 3 * k);
    while (cyc < e0 + 19) begin
      chk("idle_wr_ready", 64'(cfg_if.cfg_ready), 64'd1);
      step();
    end
    drop();

    // update mid-period: old period completes, then div=2
    do_reset();
    start_run();
    push(1, e0 + 8);
    for (int k = 1; k <= 6; k++) push(1, e0 + 8 + 2 * k);
    run_to(e0 + 3);
    chk("pre_accept_ready", 64'(cfg_if.cfg_ready), 64'd1);
    cfg_write(1'b1, 2);
    while (cyc < e0 + 8) begin
      chk("pending_ready", 64'(cfg_if.cfg_ready), 64'd0);
      step();
    end
    chk("applied_ready", 64'(cfg_if.cfg_ready), 64'd1);
    run_to(e0 + 20);
    drop();

    // accept on the wrap edge, then div=0 stored as 1
    do_reset();
    start_run();
    push(1, e0 + 8);
    push(1, e0 + 16);
    push(1, e0 + 21);
    push(1, e0 + 26);
    push(1, e0 + 31);
    for (int k = 32; k <= 36; k++) push(1, e0 + k);
    run_to(e0 + 7);
    cfg_write(1'b1, 5);
    chk("wrap_accept_ready", 64'(cfg_if.cfg_ready), 64'd0);
    run_to(e0 + 16);
    chk("wrap_applied_ready", 64'(cfg_if.cfg_ready), 64'd1);
    run_to(e0 + 26);
    cfg_write(1'b1, 0);
    run_to(e0 + 36);
    drop();

    // drop enable with update pending, then immediate restart
    do_reset();
    start_run();
    push(1, e0 + 8);
    run_to(e0 + 9);
    cfg_write(1'b1, 4);
    chk("stop_pending_ready", 64'(cfg_if.cfg_ready), 64'd0);
    step();
    chk("stop_pre_clk", 64'(clk_out), 64'd2);
    enable = 1'b0;
    step();
    chk("stop_tick", 64'(tick_out), 64'd0);
    chk("stop_clk", 64'(clk_out), 64'd0);
    chk("stop_running", 64'(running), 64'd0);
    chk("stop_ready", 64'(cfg_if.cfg_ready), 64'd1);
    start_run();
    push(1, e0 + 4);
    push(1, e0 + 8);
    run_to(e0 + 9);
    drop();

    // reset in RUN discards the pending value
    do_reset();
    start_run();
    run_to(e0 + 2);
    cfg_write(1'b1, 3);
    chk("rst_pending_ready", 64'(cfg_if.cfg_ready), 64'd0);
    run_to(e0 + 5);
    rst = 1'b1;
    step();
    chk("midrun_rst_running", 64'(running), 64'd0);
    chk("midrun_rst_tick", 64'(tick_out), 64'd0);
    chk("midrun_rst_clk", 64'(clk_out), 64'd0);
    chk("midrun_rst_ready", 64'(cfg_if.cfg_ready), 64'd1);
    rst = 1'b0;
    step();
    e0 = cyc;
    nxt_lvl[0] = 1'b1;
    nxt_lvl[1] = 1'b1;
    push(1, e0 + 8);
    push(1, e0 + 16);
    run_to(e0 + 17);
    drop();

    // channel 0 with div=0 ticks every cycle
    do_reset();
    cfg_write(1'b0, 0);
    chk("ch0_idle_ready", 64'(cfg_if.cfg_ready), 64'd1);
    start_run();
    for (int k = 1; k <= 6; k++) push(0, e0 + k);
    run_to(e0 + 6);
    drop();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rate_scheduler.md
RATE_SCHEDULER -- requirements
Module: rate_scheduler

Interface
REQ-001 Parameter WIDTH, default 32: width of divisor and counter registers.
REQ-002 Parameter DEFAULT_DIV0, default 1000: channel 0 divisor after reset.
REQ-003 Parameter DEFAULT_DIV1, default 8: channel 1 divisor after reset.
REQ-004 clk_in  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  high = run dividers; low = stop and clear.
REQ-007 cfg_valid  input  1  divisor update request.
REQ-008 cfg_ready  output  1  update accepted on an edge with cfg_valid high.
REQ-009 cfg_sel  input  1  target channel of the update.
REQ-010 cfg_div  input  WIDTH  new divisor, in cycles per half-period.
REQ-011 tick_out  output  2  per-channel one-cycle strobe at each period wrap.
REQ-012 clk_out  output  2  per-channel square wave that toggles on each tick.
REQ-013 running  output  1  high while in state RUN.

Function
REQ-014 FSM states: IDLE and RUN. IDLE goes to RUN on an edge with enable=1. RUN goes to IDLE on an edge with enable=0.
REQ-015 On entry to RUN, both channel counters start at 0. In RUN, each counter increments by 1 per cycle.
REQ-016 Channel i wraps on the edge where count_i==div_i-1: count_i<=0, tick_out[i]<=1 for exactly one cycle, clk_out[i] toggles.
REQ-017 First tick of each channel comes div_i cycles after the edge that entered RUN. Subsequent ticks are div_i apart, so the clk_out period is 2*div_i cycles.
REQ-018 A cfg_div of 0 is stored as 1. With div=1, the channel ticks every cycle and clk_out toggles every cycle.
REQ-019 Handshake: an update transfers on an edge with cfg_valid&&cfg_ready. cfg_ready=0 while any update is pending; otherwise cfg_ready=1.
REQ-020 Update accepted in IDLE: div_sel<=value on the same edge, and nothing is left pending.
REQ-021 Update accepted in RUN: the value is held pending. It is applied at that channel's next wrap, and that wrap is not the accept edge itself. The current period completes with the old divisor.
REQ-022 Accept coincides with a wrap of the target channel: the value stays pending and is applied at the following wrap.
REQ-023 Transition RUN to IDLE: counters<=0, tick_out<=0, clk_out<=0 on the same edge. Any pending update is applied immediately.
REQ-024 enable toggled back high in the cycle right after IDLE entry: restart follows REQ-015, with no residual phase.
REQ-025 Counters never exceed div_i-1. No overflow is possible for divisors up to 2^WIDTH-1.
REQ-026 tick_out, clk_out, running and cfg_ready are driven from registers or simple register decode. There are no combinational paths from cfg_* to any output.

Reset
REQ-027 On rst=1 at an edge: state=IDLE, counters=0, tick_out=0, clk_out=0, running=0, pending cleared, cfg_ready=1, div0=DEFAULT_DIV0, div1=DEFAULT_DIV1.
REQ-028 rst has priority over enable and cfg_valid, including in RUN mid-period and with an update pending. The pending value is discarded.

Structure
REQ-029 A shared package holds the FSM state encodings (IDLE, RUN), the channel count (2), and the default WIDTH.
REQ-030 Per-channel logic (counter, divisor register, pending register, tick, clk_out) lives in sub-module rate_channel, instantiated twice. rate_scheduler holds the FSM and handshake arbitration.

Verification
REQ-031 Reset with defaults, enable=1 at edge E: tick_out[1] pulses after edges E+8, E+16, …; tick_out[0] after E+1000; clk_out[1] period 16 cycles.
REQ-032 In IDLE, write ch1 div=3, then enable: ticks every 3 cycles from the first. cfg_ready stays 1 throughout.
REQ-033 In RUN with ch1 div=8, write div=2 at count 3: the remaining old period gives a tick at count 7; then ticks every 2 cycles. cfg_ready is 0 from the accept until the applying wrap.
REQ-034 Write ch1 div=5 on the exact wrap edge: one more period of 8, then periods of 5. Write cfg_div=0: ticks every cycle.
REQ-035 Drop enable mid-period with an update pending: next cycle all outputs are 0, running=0, the new divisor is in effect, and cfg_ready=1.
REQ-036 Assert rst during RUN with an update pending: state matches REQ-027 after one edge; the pending value is lost and defaults are restored.
